// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types and constants used across the pipeline stages.
package rv32i_types;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } if_state_t;

  // addi x0,x0,0 -- the canonical bubble for flushes and empty slots
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic PC/instruction pipeline register with flush > stall > load > bubble priority.
module if_id_reg
  import rv32i_types::*;
#(
  parameter int                 DATA_W = 32,
  parameter logic [DATA_W-1:0]  BUBBLE = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              load,
  input  logic [31:0]       pc_in,
  input  logic [DATA_W-1:0] instr_in,
  output logic [31:0]       pc_out,
  output logic [DATA_W-1:0] instr_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out    <= '0;
      instr_out <= BUBBLE;
    end else if (flush) begin
      pc_out    <= '0;
      instr_out <= BUBBLE;
    end else if (stall) begin
      pc_out    <= pc_out;
      instr_out <= instr_out;
    end else if (load) begin
      pc_out    <= pc_in;
      instr_out <= instr_in;
    end else begin
      pc_out    <= '0;
      instr_out <= BUBBLE;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, issues single-outstanding imem reads and feeds the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0060,
  parameter logic [31:0] NOP_INSTR = rv32i_types::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  input  logic        PCWrite,
  input  logic        if_id_write,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic [31:0] imem_address,
  output logic        imem_read,
  output logic        IF_resp,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_Instruction
);
  import rv32i_types::*;

  if_state_t   state_q;
  logic [31:0] pc_q;
  logic [31:0] buf_q;
  logic [31:0] redirect_q;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        accept;

  always_comb begin
    imem_address = pc_q;
    imem_read    = (state_q != HOLD);
    fetch_valid  = ((state_q == FETCH) && imem_resp) || (state_q == HOLD);
    fetch_instr  = (state_q == HOLD) ? buf_q : imem_rdata;
    IF_resp      = fetch_valid && !PCSrc;
    accept       = IF_resp && PCWrite && if_id_write;
  end

  // A redirect during an outstanding read keeps pc_q (the address the memory
  // is still serving) and parks the target in redirect_q until the stale response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      state_q    <= FETCH;
      buf_q      <= '0;
      redirect_q <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (PCSrc) begin
            if (imem_resp) begin
              pc_q <= branch_target;
            end else begin
              redirect_q <= branch_target;
              state_q    <= DISCARD;
            end
          end else if (imem_resp) begin
            if (accept) begin
              pc_q <= pc_next(pc_q);
            end else begin
              buf_q   <= imem_rdata;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (PCSrc) begin
            pc_q    <= branch_target;
            state_q <= FETCH;
          end else if (accept) begin
            pc_q    <= pc_next(pc_q);
            state_q <= FETCH;
          end
        end
        DISCARD: begin
          if (imem_resp) begin
            pc_q    <= PCSrc ? branch_target : redirect_q;
            state_q <= FETCH;
          end else if (PCSrc) begin
            redirect_q <= branch_target;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  if_id_reg #(
    .DATA_W (32),
    .BUBBLE (NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (PCSrc),
    .stall     (!if_id_write),
    .load      (accept),
    .pc_in     (pc_q),
    .instr_in  (fetch_instr),
    .pc_out    (ID_PC),
    .instr_out (ID_Instruction)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed plus randomized bench for if_stage against a transaction-level fetch model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0060;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic        PCWrite;
  logic        if_id_write;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] imem_address;
  logic        imem_read;
  logic        IF_resp;
  logic [31:0] ID_PC;
  logic [31:0] ID_Instruction;

  int n_assert = 0;
  int n_fail   = 0;

  // model: next address to fetch, whether the outstanding read is stale,
  // whether a fetched word is parked waiting for ID, and the ID contents
  logic [31:0] m_pc, m_redir, m_buf, m_id_pc, m_id_instr;
  bit          m_stale, m_have;
  int          lat;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .PCSrc          (PCSrc),
    .branch_target  (branch_target),
    .PCWrite        (PCWrite),
    .if_id_write    (if_id_write),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .imem_address   (imem_address),
    .imem_read      (imem_read),
    .IF_resp        (IF_resp),
    .ID_PC          (ID_PC),
    .ID_Instruction (ID_Instruction)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_redir = '0; m_buf = '0; m_stale = 0; m_have = 0;
    m_id_pc = '0; m_id_instr = NOP;
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check ID after the edge.
  task automatic cycle(input bit pcsrc, input logic [31:0] bt, input bit pcw,
                       input bit ifw, input bit resp);
    bit          valid_now, ifr, acc;
    logic [31:0] instr_now;
    PCSrc = pcsrc; branch_target = bt; PCWrite = pcw; if_id_write = ifw;
    imem_resp  = resp;
    imem_rdata = resp ? word(imem_address) : $urandom;
    #1;
    valid_now = m_have || (!m_stale && resp);
    instr_now = m_have ? m_buf : imem_rdata;
    ifr = valid_now && !pcsrc;
    acc = ifr && pcw && ifw;
    chk("imem_address", imem_address, m_pc);
    chk("imem_read", {31'd0, imem_read}, {31'd0, !m_have});
    chk("IF_resp", {31'd0, IF_resp}, {31'd0, ifr});
    if (pcsrc) begin
      m_id_pc = '0; m_id_instr = NOP;
    end else if (ifw) begin
      if (acc) begin m_id_pc = m_pc; m_id_instr = instr_now; end
      else     begin m_id_pc = '0;   m_id_instr = NOP;       end
    end
    if (m_stale) begin
      if (resp) begin m_stale = 0; m_pc = pcsrc ? bt : m_redir; end
      else if (pcsrc) m_redir = bt;
    end else if (m_have) begin
      if (pcsrc)    begin m_have = 0; m_pc = bt; end
      else if (acc) begin m_have = 0; m_pc = m_pc + 32'd4; end
    end else if (pcsrc) begin
      if (resp) m_pc = bt;
      else begin m_stale = 1; m_redir = bt; end
    end else if (resp) begin
      if (acc) m_pc = m_pc + 32'd4;
      else begin m_have = 1; m_buf = imem_rdata; end
    end
    @(posedge clk); #1;
    chk("ID_PC", ID_PC, m_id_pc);
    chk("ID_Instruction", ID_Instruction, m_id_instr);
  endtask

  initial begin
    rst = 1'b1; PCSrc = 0; branch_target = '0; PCWrite = 1; if_id_write = 1;
    imem_rdata = '0; imem_resp = 0;
    model_reset();
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);

    // asynchronous reset mid-run
    #2 rst = 1'b1; #1;
    chk("rst_address", imem_address, RPC);
    chk("rst_id_instr", ID_Instruction, NOP);
    chk("rst_id_pc", ID_PC, 32'd0);
    chk("rst_read", {31'd0, imem_read}, 32'd1);
    model_reset();
    @(posedge clk); #1; rst = 1'b0;

    // back-to-back fetch
    chk("seq_addr0", imem_address, 32'h60);
    cycle(0, 0, 1, 1, 1);
    chk("seq_id0", ID_PC, 32'h60);
    chk("seq_instr0", ID_Instruction, word(32'h60));
    chk("seq_addr1", imem_address, 32'h64);
    cycle(0, 0, 1, 1, 1);
    chk("seq_id1", ID_PC, 32'h64);
    chk("seq_addr2", imem_address, 32'h68);
    cycle(0, 0, 1, 1, 1);

    // three-cycle memory latency
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 1, 0);
      chk("lat_bubble", ID_Instruction, NOP);
      chk("lat_addr", imem_address, 32'h6C);
    end
    cycle(0, 0, 1, 1, 1);
    chk("lat_instr", ID_Instruction, word(32'h6C));

    // response under a two-cycle stall parks the word
    cycle(0, 0, 0, 0, 1);
    chk("hold_read", {31'd0, imem_read}, 32'd0);
    chk("hold_id", ID_PC, 32'h6C);
    cycle(0, 0, 0, 0, 0);
    chk("hold_id2", ID_Instruction, word(32'h6C));
    cycle(0, 0, 1, 1, 0);
    chk("hold_release", ID_Instruction, word(32'h70));
    chk("hold_next", imem_address, 32'h74);

    // redirect while the read to 0x80 is outstanding
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 1);
    chk("pre_redirect", imem_address, 32'h80);
    cycle(1, 32'h200, 1, 1, 0);
    chk("discard_addr", imem_address, 32'h80);
    cycle(0, 0, 1, 1, 1);
    chk("discard_drop", ID_Instruction, NOP);
    chk("discard_target", imem_address, 32'h200);
    cycle(0, 0, 1, 1, 1);
    chk("redirect_id", ID_PC, 32'h200);

    // flush beats stall on a response cycle
    cycle(1, 32'h300, 1, 0, 1);
    chk("flush_instr", ID_Instruction, NOP);
    chk("flush_pc", imem_address, 32'h300);

    // PC wrap
    cycle(1, 32'hFFFF_FFFC, 1, 1, 1);
    cycle(0, 0, 1, 1, 1);
    chk("wrap_id", ID_PC, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_address, 32'h0);

    // randomized traffic with variable latency
    lat = 0;
    for (int i = 0; i < 2000; i++) begin
      bit pcs, resp;
      resp = imem_read && (lat == 0);
      if (resp) lat = $urandom_range(0, 3);
      else if (imem_read) lat--;
      pcs = ($urandom_range(0, 9) == 0);
      cycle(pcs, {16'd0, 14'($urandom_range(1, 16'h3FFF)), 2'b00},
            ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0), resp);
      if (ID_PC != 32'd0) chk("id_word_match", ID_Instruction, word(ID_PC));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
